alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
Sits directly downstream of Adder_8bits in the Gumnut datapath and consumes its sum, carry-out and overflow outputs.
- Registers each ALU result into a 2-entry skid buffer with a valid/ready handshake toward register-file writeback.
- Maintains the architectural condition flags Z, C, N and V.
- Holds a shadow copy of the flags for interrupt entry and return (save on interrupt, restore on reti).

Parameters:
DATA_W, 8, width of the result datapath; must match the adder width.
DEST_W, 3, width of the destination-register tag carried alongside each result.

Ports:
clk_i  in  1  system clock; all state updates on the rising edge.
rst_i  in  1  synchronous, active-high reset.
in_valid  in  1  upstream result valid.
in_ready  out  1  stage can accept a result.
in_result  in  DATA_W  adder sum (C).
in_cout  in  1  adder carry-out.
in_ov  in  1  adder signed overflow.
in_dest  in  DEST_W  destination register tag.
in_upd_zc  in  1  accepted op updates Z and C.
in_upd_nv  in  1  accepted op updates N and V.
out_valid  out  1  head entry valid.
out_ready  in  1  writeback consumes the head entry.
out_result  out  DATA_W  head entry result.
out_dest  out  DEST_W  head entry tag.
flag_z, flag_c, flag_n, flag_v  out  1 each  architectural flags (registered).
int_save  in  1  copy the flags into the shadow register.
int_restore  in  1  copy the shadow register into the flags.

Behaviour:
- Reset values (next edge with rst_i=1):
  - count=0, out_valid=0, in_ready=1.
  - out_result=0, out_dest=0.
  - All four flags and all four shadow flags = 0.
- Reset applied mid-operation flushes both entries and discards any push, pop, save or restore in that cycle.
- Accept when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count != 2), decoded directly from the count register with no combinational path from out_ready.
- Latency: a result accepted at edge k appears on out_* after edge k (1 cycle). Results leave in FIFO order.
- Count transitions:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together: count unchanged; the head advances and the new entry goes to the tail.
  - count=2 with in_valid: no accept; upstream holds its inputs.
  - count=0: pop is impossible because out_valid=0.
  - Storage is two slots with head/tail pointers that wrap modulo 2.
- Flag update is applied on accept, not on pop:
  - If in_upd_zc: Z = (in_result == 0), C = in_cout.
  - If in_upd_nv: N = in_result[DATA_W-1], V = in_ov.
  - Flags whose update enable is 0 hold their value.
- Flags reflect the most recently accepted op, independent of back-pressure.
- Shadow save/restore:
  - int_save: shadow <= next-cycle flag values, including any update from an accept in the same cycle.
  - int_restore: flags <= shadow.
  - Restore and accept in the same cycle: flags written by the accept take the accepted values; the rest take shadow values.
  - int_save and int_restore in the same cycle: restore wins; the shadow is unchanged.
- No arithmetic is done here. Widths are fixed at DATA_W with no extension or truncation.

Decomposition:
- Shared package gumnut_pkg holds:
  - DATA_W and DEST_W constants.
  - Flag bit indices FLAG_Z=0, FLAG_C=1, FLAG_N=2, FLAG_V=3.
  - A 4-bit flags typedef.
  - A result-entry typedef {result, dest}.
- One sub-module is natural: skid_buffer2 (the generic 2-entry valid/ready buffer). Flag and shadow logic stays in the top level.

Test Plan:
1. Reset, then rst_i=0 → out_valid=0, in_ready=1, flags=0000, shadow=0000.
2. Push result=0x00, cout=1, ov=0, upd_zc=1, upd_nv=1, out_ready=1 → next cycle: out_valid=1, out_result=0x00, Z=1, C=1, N=0, V=0. The following cycle: out_valid=0.
3. Back-pressure with out_ready=0: push 0x7F (dest 1), 0x80 (dest 2), then offer 0x11 → in_ready=0 after the 2nd accept and 0x11 is held. Raise out_ready → outputs in order 0x7F, 0x80, 0x11. Flags follow accept order: after 0x80, N=1.
4. Masked update: from Z=1/C=1, push 0x80 with cout=0, ov=1, upd_zc=0, upd_nv=1 → Z=1, C=1, N=1, V=1.
5. Interrupt flags:
   - With Z=1, C=1: int_save, then push 0x05 (cout=0, upd all) → Z=0, C=0.
   - Then int_restore → Z=1, C=1.
   - Repeat with restore in the same cycle as an accept of 0x80 using upd_zc=0, upd_nv=1 → Z, C from shadow; N=1.
6. Reset mid-operation with count=2 and an in_valid pending → next cycle: out_valid=0, in_ready=1, flags=0, and the pending input is not captured.

Source files
------------

// File: rtl/gumnut_pkg.sv
// Shared Gumnut datapath types: widths, flag indices and the
// result entry bundle carried from the adder to writeback.
package gumnut_pkg;

  localparam int DATA_W = 8;
  localparam int DEST_W = 3;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef logic [3:0] flags_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DEST_W-1:0] dest;
  } entry_t;

endpackage

// File: rtl/skid_buffer2.sv
// Generic 2-entry valid/ready buffer; in_ready depends only on
// the occupancy register, never on out_ready.
module skid_buffer2 #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic         head;
  logic         tail;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[head];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count  <= 2'd0;
      head   <= 1'b0;
      tail   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[tail] <= in_data;
        tail      <= ~tail;
      end
      if (pop)
        head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Adder result stage: buffers results toward writeback and owns
// the Z/C/N/V flags plus their interrupt shadow copy.
module alu_result_stage
  import gumnut_pkg::*;
#(
  parameter int DATA_W = gumnut_pkg::DATA_W,
  parameter int DEST_W = gumnut_pkg::DEST_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_cout,
  input  logic              in_ov,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_upd_zc,
  input  logic              in_upd_nv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_n,
  output logic              flag_v,
  input  logic              int_save,
  input  logic              int_restore
);

  entry_t in_entry;
  entry_t out_entry;
  flags_t flags;
  flags_t shadow;
  flags_t flags_next;
  logic   accept;

  assign in_entry.result = in_result;
  assign in_entry.dest   = in_dest;

  skid_buffer2 #(
    .W($bits(entry_t))
  ) u_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_entry)
  );

  assign out_result = out_entry.result;
  assign out_dest   = out_entry.dest;
  assign accept     = in_valid && in_ready;

  // Accepted op overrides the restored value for the bits it writes.
  always_comb begin
    flags_next = int_restore ? shadow : flags;
    if (accept && in_upd_zc) begin
      flags_next[FLAG_Z] = (in_result == '0);
      flags_next[FLAG_C] = in_cout;
    end
    if (accept && in_upd_nv) begin
      flags_next[FLAG_N] = in_result[DATA_W-1];
      flags_next[FLAG_V] = in_ov;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flags  <= '0;
      shadow <= '0;
    end else begin
      flags <= flags_next;
      if (int_save && !int_restore)
        shadow <= flags_next;
    end
  end

  assign flag_z = flags[FLAG_Z];
  assign flag_c = flags[FLAG_C];
  assign flag_n = flags[FLAG_N];
  assign flag_v = flags[FLAG_V];

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_result;
  logic       in_cout;
  logic       in_ov;
  logic [2:0] in_dest;
  logic       in_upd_zc;
  logic       in_upd_nv;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [2:0] out_dest;
  logic       flag_z, flag_c, flag_n, flag_v;
  logic       int_save;
  logic       int_restore;

  int checks = 0;
  int fails  = 0;

  logic [3:0] f;
  assign f = {flag_v, flag_n, flag_c, flag_z};

  alu_result_stage dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_cout     (in_cout),
    .in_ov       (in_ov),
    .in_dest     (in_dest),
    .in_upd_zc   (in_upd_zc),
    .in_upd_nv   (in_upd_nv),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_dest    (out_dest),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .flag_n      (flag_n),
    .flag_v      (flag_v),
    .int_save    (int_save),
    .int_restore (int_restore)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [7:0] r, input logic co,
                       input logic ov, input logic [2:0] d,
                       input logic zc, input logic nv);
    in_valid  = 1'b1;
    in_result = r;
    in_cout   = co;
    in_ov     = ov;
    in_dest   = d;
    in_upd_zc = zc;
    in_upd_nv = nv;
  endtask

  task automatic test_reset;
    drive(8'h00, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1);
    out_ready = 1'b0;
    tick;
    int_save = 1'b1;
    in_valid = 1'b0;
    tick;
    int_save = 1'b0;
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (f !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags got %b want 0000", f);
    end
    checks++;
    if (out_result !== 8'h00 || out_dest !== 3'd0) begin
      fails++;
      $display("FAIL reset_out got %h/%0d want 00/0",
               out_result, out_dest);
    end
    int_restore = 1'b1;
    tick;
    int_restore = 1'b0;
    checks++;
    if (f !== 4'b0000) begin
      fails++;
      $display("FAIL reset_shadow got %b want 0000", f);
    end
  endtask

  task automatic test_single_push;
    out_ready = 1'b1;
    drive(8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1);
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 8'h00 ||
        out_dest !== 3'd3) begin
      fails++;
      $display("FAIL single_out got v=%b %h/%0d want v=1 00/3",
               out_valid, out_result, out_dest);
    end
    checks++;
    if (f !== 4'b0011) begin
      fails++;
      $display("FAIL single_flags got %b want 0011", f);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_pressure;
    out_ready = 1'b0;
    drive(8'h7F, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1);
    tick;
    checks++;
    if (in_ready !== 1'b1 || f !== 4'b0000) begin
      fails++;
      $display("FAIL bp_first got rdy=%b f=%b want 1/0000",
               in_ready, f);
    end
    drive(8'h80, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1);
    tick;
    checks++;
    if (in_ready !== 1'b0 || f !== 4'b1100) begin
      fails++;
      $display("FAIL bp_full got rdy=%b f=%b want 0/1100",
               in_ready, f);
    end
    drive(8'h11, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1);
    tick;
    checks++;
    if (in_ready !== 1'b0 || out_result !== 8'h7F ||
        out_dest !== 3'd1 || f !== 4'b1100) begin
      fails++;
      $display("FAIL bp_hold got rdy=%b %h/%0d f=%b want 0 7f/1 1100",
               in_ready, out_result, out_dest, f);
    end
    out_ready = 1'b1;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 8'h80 ||
        out_dest !== 3'd2 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_pop1 got v=%b %h/%0d rdy=%b want 1 80/2 1",
               out_valid, out_result, out_dest, in_ready);
    end
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 8'h11 ||
        out_dest !== 3'd3) begin
      fails++;
      $display("FAIL bp_pop2 got v=%b %h/%0d want 1 11/3",
               out_valid, out_result, out_dest);
    end
    checks++;
    if (f !== 4'b0010) begin
      fails++;
      $display("FAIL bp_flags got %b want 0010", f);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_empty got %b want 0", out_valid);
    end
  endtask

  task automatic test_masked;
    out_ready = 1'b1;
    drive(8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    tick;
    checks++;
    if (f !== 4'b0011) begin
      fails++;
      $display("FAIL mask_zc got %b want 0011", f);
    end
    drive(8'h80, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
    tick;
    in_valid = 1'b0;
    checks++;
    if (f !== 4'b1111) begin
      fails++;
      $display("FAIL mask_nv got %b want 1111", f);
    end
    tick;
  endtask

  task automatic test_interrupt;
    out_ready = 1'b1;
    int_save = 1'b1;
    tick;
    int_save = 1'b0;
    drive(8'h05, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
    tick;
    in_valid = 1'b0;
    checks++;
    if (f !== 4'b0000) begin
      fails++;
      $display("FAIL irq_clobber got %b want 0000", f);
    end
    int_restore = 1'b1;
    tick;
    int_restore = 1'b0;
    checks++;
    if (f !== 4'b1111) begin
      fails++;
      $display("FAIL irq_restore got %b want 1111", f);
    end
    drive(8'h05, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
    tick;
    drive(8'h80, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1);
    int_restore = 1'b1;
    tick;
    int_restore = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (f !== 4'b0111) begin
      fails++;
      $display("FAIL irq_restore_acc got %b want 0111", f);
    end
    // Save while an accept lands: shadow must capture the new flags.
    int_save = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0);
    tick;
    int_save = 1'b0;
    checks++;
    if (f !== 4'b0101) begin
      fails++;
      $display("FAIL irq_save_acc got %b want 0101", f);
    end
    drive(8'h05, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
    tick;
    in_valid = 1'b0;
    int_restore = 1'b1;
    tick;
    int_restore = 1'b0;
    checks++;
    if (f !== 4'b0101) begin
      fails++;
      $display("FAIL irq_shadow_acc got %b want 0101", f);
    end
    int_save = 1'b1;
    int_restore = 1'b1;
    drive(8'h05, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
    tick;
    int_save = 1'b0;
    int_restore = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (f !== 4'b0000) begin
      fails++;
      $display("FAIL irq_both_acc got %b want 0000", f);
    end
    int_restore = 1'b1;
    tick;
    int_restore = 1'b0;
    checks++;
    if (f !== 4'b0101) begin
      fails++;
      $display("FAIL irq_both_keep got %b want 0101", f);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    drive(8'h33, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1);
    tick;
    drive(8'h44, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1);
    tick;
    checks++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_full got %b want 0", in_ready);
    end
    drive(8'h22, 1'b1, 1'b1, 3'd6, 1'b1, 1'b1);
    int_save = 1'b1;
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    int_save = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        f !== 4'b0000 || out_result !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset got v=%b rdy=%b f=%b r=%h",
               out_valid, in_ready, f, out_result);
    end
    out_ready = 1'b1;
    int_restore = 1'b1;
    tick;
    int_restore = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || f !== 4'b0000) begin
      fails++;
      $display("FAIL mid_after got v=%b f=%b want 0/0000",
               out_valid, f);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    in_valid = 1'b0;
    in_result = '0;
    in_cout = 1'b0;
    in_ov = 1'b0;
    in_dest = '0;
    in_upd_zc = 1'b0;
    in_upd_nv = 1'b0;
    out_ready = 1'b0;
    int_save = 1'b0;
    int_restore = 1'b0;
    tick;
    rst_i = 1'b0;
    test_reset;
    test_single_push;
    test_back_pressure;
    test_masked;
    test_interrupt;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
